// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div sequencer owning HI/LO, with D-stage stall generation.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        use_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] opReg;
  logic [31:0] aReg, bReg, aAbs, bAbs, uQ, uR, sQ, sR, resHi, resLo;
  logic [63:0] sProd, uProd;
  logic aNeg, bNeg;
  // Signed division is done on magnitudes, which also makes 0x80000000 / -1 wrap to 0x80000000.
  always_comb begin
    sProd = $signed({{32{aReg[31]}}, aReg}) * $signed({{32{bReg[31]}}, bReg});
    uProd = {32'b0, aReg} * {32'b0, bReg};
    aNeg = ~opReg[0] & aReg[31];
    bNeg = ~opReg[0] & bReg[31];
    aAbs = aNeg ? -aReg : aReg;
    bAbs = bNeg ? -bReg : bReg;
    uQ = bAbs == 32'd0 ? 32'd0 : aAbs / bAbs;
    uR = bAbs == 32'd0 ? 32'd0 : aAbs % bAbs;
    sQ = (aNeg ^ bNeg) ? -uQ : uQ;
    sR = aNeg ? -uR : uR;
    resHi = opReg[1] ? (bReg == 32'd0 ? aReg : sR) : (opReg[0] ? uProd[63:32] : sProd[63:32]);
    resLo = opReg[1] ? (bReg == 32'd0 ? 32'hFFFF_FFFF : sQ) : (opReg[0] ? uProd[31:0] : sProd[31:0]);
  end
  assign md_stall = use_md & (busy | (start & ~op[2]));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      hi <= '0;
      lo <= '0;
      opReg <= '0;
      aReg <= '0;
      bReg <= '0;
    end else if (state == IDLE) begin
      if (start && !cancel) begin
        if (!op[2]) begin
          opReg <= op[1:0];
          aReg <= a;
          bReg <= b;
          cnt <= op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          state <= BUSY;
          busy <= 1'b1;
        end else if (op == 3'd4) hi <= a;
        else if (op == 3'd5) lo <= a;
      end
    end else if (cancel) begin
      state <= IDLE;
      busy <= 1'b0;
    end else if (cnt != '0) cnt <= cnt - CW'(1);
    else begin
      hi <= resHi;
      lo <= resLo;
      state <= IDLE;
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench; expected HI/LO queued at issue, checked when busy falls.
module tb_md_sched;
  logic clk = 0, reset = 1, start = 0, cancel = 0, use_md = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, md_stall;
  logic [31:0] hi, lo;
  int compared = 0, mismatched = 0;
  logic [63:0] q[$];

  md_sched dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
                .use_md(use_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge of busy (completion, cancel or reset) pops one expectation.
  initial begin
    logic prevBusy;
    logic [63:0] e;
    prevBusy = 0;
    forever begin
      @(negedge clk);
      if (prevBusy && !busy) begin
        if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("hi", hi, e[63:32]);
          check("lo", lo, e[31:0]);
        end
      end
      prevBusy = busy;
    end
  end

  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input int n,
                       input int cancelAt, input bit chkStall);
    int c;
    @(negedge clk);
    start = 1; op = o; a = x; b = y; use_md = chkStall;
    q.push_back({eh, el});
    #1;
    check("busy_start", {31'b0, busy}, 32'd0);
    if (chkStall) check("stall_start", {31'b0, md_stall}, 32'd1);
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    c = 0;
    while (busy && c < 200) begin
      c++;
      start = (cancelAt != 0 && c == 2);
      op = 3'd4;
      cancel = (c == cancelAt);
      #1;
      if (chkStall) check("stall_busy", {31'b0, md_stall}, 32'd1);
      @(negedge clk);
    end
    start = 0; cancel = 0;
    check("busy_cycles", c, cancelAt != 0 ? cancelAt : n);
    #1;
    if (chkStall) check("stall_done", {31'b0, md_stall}, 32'd0);
    use_md = 0;
  endtask

  initial begin
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    runOp(3'd0, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 0, 0);
    runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 0, 0);
    runOp(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0, 0);
    runOp(3'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, 0);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, 0);
    runOp(3'd2, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 10, 0, 0);
    runOp(3'd3, 32'hF000_0005, 32'd0, 32'hF000_0005, 32'hFFFF_FFFF, 10, 0, 0);
    runOp(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0, 1);
    @(negedge clk); start = 1; op = 3'd4; a = 32'd5;
    @(negedge clk); start = 1; op = 3'd5; a = 32'd9;
    check("mthi", hi, 32'd5);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); start = 1; op = 3'd6; a = 32'd1;
    check("mtlo", lo, 32'd9);
    @(negedge clk); start = 0;
    check("noop_hi", hi, 32'd5);
    check("noop_lo", lo, 32'd9);
    runOp(3'd2, 32'd100, 32'd7, 32'd5, 32'd9, 10, 3, 1);
    runOp(3'd0, 32'd3, 32'd3, 32'd5, 32'd9, 5, 5, 0);
    @(negedge clk); start = 1; op = 3'd5; a = 32'd77; cancel = 1;
    @(negedge clk); start = 0; cancel = 0;
    check("cancel_start_lo", lo, 32'd9);
    check("cancel_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); start = 1; op = 3'd2; a = 32'd50; b = 32'd3;
    q.push_back(64'd0);
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1;
    #1;
    check("areset_busy", {31'b0, busy}, 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd0);
    @(negedge clk); #1 reset = 0;
    runOp(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 0, 0);
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
